// File: rtl/oclib_pkg.sv
// Shared oclib types: CSR request/response words and boolean parameter constants.
package oclib_pkg;

  localparam bit False = 1'b0;
  localparam bit True  = 1'b1;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        read;
    logic        write;
  } csr_32_s;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
    logic        error;
  } csr_32_fb_s;

endpackage

// File: rtl/oclib_module_reset.sv
// Optional reset synchronizer followed by optional reset pipeline stages.
// Latency is SyncCycles (when enabled) plus ResetPipeline cycles; zero when both are off.
module oclib_module_reset #(
  parameter bit ResetSync     = 1'b0,
  parameter int SyncCycles    = 3,
  parameter int ResetPipeline = 0
) (
  input  logic clock,
  input  logic resetIn,
  output logic resetOut
);

  logic syncReset;
  logic unusedClock;

  assign unusedClock = clock;

  if (ResetSync) begin : gSync
    logic [SyncCycles-1:0] chain;
    always_ff @(posedge clock) begin
      chain[0] <= resetIn;
      for (int i = 1; i < SyncCycles; i++) chain[i] <= chain[i-1];
    end
    assign syncReset = chain[SyncCycles-1];
  end else begin : gNoSync
    assign syncReset = resetIn;
  end

  if (ResetPipeline > 0) begin : gPipe
    logic [ResetPipeline-1:0] pipe;
    always_ff @(posedge clock) begin
      pipe[0] <= syncReset;
      for (int i = 1; i < ResetPipeline; i++) pipe[i] <= pipe[i-1];
    end
    assign resetOut = pipe[ResetPipeline-1];
  end else begin : gNoPipe
    assign resetOut = syncReset;
  end

endmodule

// File: rtl/oclib_rr_pick.sv
// Combinational rotate-priority picker: first set request after lastGrant, wrapping.
// Zero latency; no flow control of its own.
module oclib_rr_pick #(
  parameter int Requesters = 2,
  parameter int IdxWidth   = (Requesters > 1) ? $clog2(Requesters) : 1
) (
  input  logic [Requesters-1:0] request,
  input  logic [IdxWidth-1:0]   lastGrant,
  output logic [IdxWidth-1:0]   winner,
  output logic                  anyRequest
);

  logic                found;
  int                  idx;
  logic [IdxWidth-1:0] idxSel;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idxSel = '0;
    for (int k = 1; k <= Requesters; k++) begin
      idx    = (int'(lastGrant) + k) % Requesters;
      idxSel = IdxWidth'(idx);
      if (!found && request[idxSel]) begin
        winner = idxSel;
        found  = 1'b1;
      end
    end
  end

  assign anyRequest = |request;

endmodule

// File: rtl/oclib_csr_word_arbiter.sv
// Round-robin arbiter sharing one CSR word target among Requesters masters, one transaction in flight.
// Minimum 4 cycles per transaction; stalls on reqReady, respValid and the owner's outReady.
module oclib_csr_word_arbiter #(
  parameter int  Requesters    = 2,
  parameter type CsrType       = oclib_pkg::csr_32_s,
  parameter type CsrFbType     = oclib_pkg::csr_32_fb_s,
  parameter int  SyncCycles    = 3,
  parameter bit  ResetSync     = oclib_pkg::False,
  parameter int  ResetPipeline = 0,
  parameter int  IdxWidth      = (Requesters > 1) ? $clog2(Requesters) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  CsrType                inData [Requesters],
  input  logic [Requesters-1:0] inValid,
  output logic [Requesters-1:0] inReady,
  output CsrFbType              outData [Requesters],
  output logic [Requesters-1:0] outValid,
  input  logic [Requesters-1:0] outReady,
  output CsrType                reqData,
  output logic                  reqValid,
  input  logic                  reqReady,
  input  CsrFbType              respData,
  input  logic                  respValid,
  output logic                  respReady,
  output logic [IdxWidth-1:0]   grantId,
  output logic                  busy
);

  import oclib_pkg::*;

  typedef enum logic [1:0] {StArb, StReq, StWait, StResp} state_e;

  state_e              state;
  logic                resetQ;
  logic [IdxWidth-1:0] lastGrant;
  logic [IdxWidth-1:0] winner;
  logic                anyRequest;

  oclib_module_reset #(
    .ResetSync     (ResetSync),
    .SyncCycles    (SyncCycles),
    .ResetPipeline (ResetPipeline)
  ) uReset (
    .clock    (clock),
    .resetIn  (reset),
    .resetOut (resetQ)
  );

  oclib_rr_pick #(
    .Requesters (Requesters),
    .IdxWidth   (IdxWidth)
  ) uPick (
    .request    (inValid),
    .lastGrant  (lastGrant),
    .winner     (winner),
    .anyRequest (anyRequest)
  );

  // Accept is gated by reset so a word is never taken on an edge that aborts it.
  always_comb begin
    inReady = '0;
    if (!resetQ && (state == StArb) && anyRequest) inReady[winner] = 1'b1;
  end

  assign busy = (state != StArb);

  always_ff @(posedge clock) begin
    if (resetQ) begin
      state     <= StArb;
      lastGrant <= IdxWidth'(Requesters - 1);
      grantId   <= '0;
      reqData   <= '0;
      reqValid  <= 1'b0;
      respReady <= 1'b0;
      outValid  <= '0;
      for (int i = 0; i < Requesters; i++) outData[i] <= '0;
    end else begin
      case (state)
        StArb: begin
          if (anyRequest) begin
            reqData   <= inData[winner];
            grantId   <= winner;
            lastGrant <= winner;
            reqValid  <= 1'b1;
            state     <= StReq;
          end
        end
        StReq: begin
          if (reqReady) begin
            reqValid  <= 1'b0;
            respReady <= 1'b1;
            state     <= StWait;
          end
        end
        StWait: begin
          if (respValid && respReady) begin
            outData[grantId]  <= respData;
            outValid[grantId] <= 1'b1;
            respReady         <= 1'b0;
            state             <= StResp;
          end
        end
        StResp: begin
          if (outReady[grantId]) begin
            outValid <= '0;
            state    <= StArb;
          end
        end
        default: state <= StArb;
      endcase
    end
  end

endmodule

// File: tb/tb_oclib_csr_word_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level reference model.
module tb_oclib_csr_word_arbiter;
  import oclib_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clock = 1'b0;
  logic          reset;
  csr_32_s       inData [N];
  logic [N-1:0]  inValid;
  logic [N-1:0]  inReady;
  csr_32_fb_s    outData [N];
  logic [N-1:0]  outValid;
  logic [N-1:0]  outReady;
  csr_32_s       reqData;
  logic          reqValid;
  logic          reqReady;
  csr_32_fb_s    respData;
  logic          respValid;
  logic          respReady;
  logic [IW-1:0] grantId;
  logic          busy;

  oclib_csr_word_arbiter #(.Requesters(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .inData    (inData),
    .inValid   (inValid),
    .inReady   (inReady),
    .outData   (outData),
    .outValid  (outValid),
    .outReady  (outReady),
    .reqData   (reqData),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .respData  (respData),
    .respValid (respValid),
    .respReady (respReady),
    .grantId   (grantId),
    .busy      (busy)
  );

  initial forever #5 clock = ~clock;

  int nAsserts = 0;
  int nFail    = 0;

  // Transaction-level reference: owner, whether the request/response have been handed over, and delivered data.
  int         mLast;
  int         mGrant;
  bit         txOpen, reqSent, respGot;
  csr_32_s    mReq;
  csr_32_fb_s mOut [N];
  int         cycle;
  int         acceptId;
  bit         keepValid;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rrWinner(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic csr_32_s randReq();
    csr_32_s r;
    r.address = $urandom;
    r.wdata   = $urandom;
    r.wstrb   = 4'($urandom);
    r.read    = 1'($urandom);
    r.write   = 1'($urandom);
    return r;
  endfunction

  function automatic csr_32_fb_s randResp();
    csr_32_fb_s r;
    r.rdata = $urandom;
    r.ready = 1'($urandom);
    r.error = 1'($urandom);
    return r;
  endfunction

  // Inputs are set by the caller at posedge+1; outputs compared at posedge+2, then one edge passes.
  task automatic step();
    int w;
    w = -1;
    #1;
    if (!reset) begin
      if (!txOpen) w = rrWinner(inValid, mLast);
      chk("inReady", inReady, (w >= 0) ? (N'(1) << w) : '0);
      chk("reqValid", reqValid, txOpen && !reqSent);
      if (txOpen && !reqSent) chk("reqData", reqData, mReq);
      chk("respReady", respReady, txOpen && reqSent && !respGot);
      chk("outValid", outValid, (txOpen && respGot) ? (N'(1) << mGrant) : '0);
      for (int i = 0; i < N; i++) chk("outData", outData[i], mOut[i]);
      chk("grantId", grantId, mGrant);
      chk("busy", busy, txOpen);
    end
    acceptId = -1;
    if (reset) begin
      txOpen = 0; reqSent = 0; respGot = 0;
      mLast = N - 1; mGrant = 0;
      for (int i = 0; i < N; i++) mOut[i] = '0;
    end else if (w >= 0) begin
      acceptId = w; txOpen = 1; reqSent = 0; respGot = 0;
      mReq = inData[w]; mGrant = w; mLast = w;
    end else if (txOpen && !reqSent) begin
      if (reqReady) reqSent = 1;
    end else if (txOpen && !respGot) begin
      if (respValid) begin respGot = 1; mOut[mGrant] = respData; end
    end else if (txOpen && respGot) begin
      if (outReady[mGrant]) begin txOpen = 0; reqSent = 0; respGot = 0; end
    end
    @(posedge clock);
    cycle++;
    #1;
    if (acceptId >= 0 && !keepValid) inValid[acceptId] = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && (txOpen || inValid != '0); c++) step();
    chk("drain_busy", busy, 1'b0);
  endtask

  initial begin
    csr_32_s    w3;
    csr_32_fb_s r2;
    int         accIds[$];
    int         accCyc[$];

    reset = 1'b1; inValid = '0; outReady = '0; reqReady = 1'b0;
    respValid = 1'b0; respData = '0; keepValid = 0; cycle = 0; acceptId = -1;
    for (int i = 0; i < N; i++) inData[i] = randReq();
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
    chk("rst_reqData", reqData, '0);
    chk("rst_outValid", outValid, '0);

    // Single request from requester 1 right after reset.
    inData[1] = randReq();
    inValid[1] = 1'b1;
    step();
    chk("t1_accept", acceptId, 1);
    chk("t1_reqValid", reqValid, 1'b1);
    chk("t1_reqData", reqData, inData[1]);
    chk("t1_grantId", grantId, 1);
    reqReady = 1'b1; respValid = 1'b1; respData = randReq() == '0 ? '0 : randResp(); outReady = '1;
    drain();

    // Fairness from reset with every requester saturating and an always-ready target.
    reset = 1'b1; step(); reset = 1'b0;
    keepValid = 1; inValid = '1;
    for (int c = 0; c < 40 && accIds.size() < 5; c++) begin
      step();
      if (acceptId >= 0) begin accIds.push_back(acceptId); accCyc.push_back(cycle); end
    end
    chk("t2_grants", accIds.size(), 5);
    for (int k = 0; k < accIds.size(); k++) begin
      chk("t2_order", accIds[k], k % N);
      if (k > 0) chk("t2_spacing", accCyc[k] - accCyc[k-1], 4);
    end
    keepValid = 0; inValid = '0;
    drain();

    // Target stalls the request for 10 cycles.
    reqReady = 1'b0;
    inData[3] = randReq(); w3 = inData[3];
    inValid[3] = 1'b1;
    step();
    inData[0] = randReq(); inValid[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t3_reqValid", reqValid, 1'b1);
      chk("t3_reqData", reqData, w3);
      chk("t3_inReady", inReady, '0);
      chk("t3_busy", busy, 1'b1);
    end
    reqReady = 1'b1;
    drain();

    // Requester 2 withholds outReady for 5 cycles.
    outReady = 4'b1011; respData = randResp();
    inData[2] = randReq(); inValid[2] = 1'b1;
    for (int c = 0; c < 10 && !outValid[2]; c++) step();
    chk("t4_arrive", outValid[2], 1'b1);
    r2 = respData;
    inData[0] = randReq(); inValid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t4_outValid", outValid, 4'b0100);
      chk("t4_outData", outData[2], r2);
    end
    outReady = '1;
    step();
    chk("t4_nextGrant", inReady, 4'b0001);
    drain();

    // Spurious response while idle, then reset in the middle of a transaction.
    respValid = 1'b1; respData = randResp();
    repeat (3) begin
      step();
      chk("t5_spurious", outValid, '0);
    end
    respValid = 1'b0;
    inData[1] = randReq(); inValid[1] = 1'b1;
    step(); step();
    chk("t5_inWait", respReady, 1'b1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t5_rst_outValid", outValid, '0);
    chk("t5_rst_reqValid", reqValid, 1'b0);
    chk("t5_rst_respReady", respReady, 1'b0);
    chk("t5_rst_grantId", grantId, 0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_reqData", reqData, '0);
    for (int i = 0; i < N; i++) chk("t5_rst_outData", outData[i], '0);
    inValid = 4'b0011;
    step();
    chk("t5_grantAfterReset", acceptId, 0);
    respValid = 1'b1;
    drain();

    // Random traffic on both sides.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!inValid[i] && ($urandom % 4 == 0)) begin
          inData[i] = randReq();
          inValid[i] = 1'b1;
        end
      end
      reqReady  = 1'($urandom);
      respValid = 1'($urandom);
      respData  = randResp();
      outReady  = N'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/oclib_csr_word_arbiter.md
# oclib_csr_word_arbiter

Round-robin arbiter that shares one CSR word-stream target among `Requesters` independent word-stream masters. It accepts one request word at a time, forwards it downstream, waits for the single response word, and returns it only to the requester that issued it. It sits in front of the word-to-CSR converter so that several host channels (e.g. UART, PCIe, JTAG) can reach one CSR tree. It has exactly one transaction outstanding at any time.

## Interface
- Requesters, 2, number of upstream masters; legal range 1..16.
- CsrType, oclib_pkg::csr_32_s, request word type.
- CsrFbType, oclib_pkg::csr_32_fb_s, response word type.
- SyncCycles, 3, reset synchronizer depth.
- ResetSync, oclib_pkg::False, synchronize `reset` internally.
- ResetPipeline, 0, extra reset pipeline stages.
- IdxWidth, derived, max(1, $clog2(Requesters)).

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- inData  in  Requesters x CsrType  request words.
- inValid  in  Requesters  request valid.
- inReady  out  Requesters  request accept.
- outData  out  Requesters x CsrFbType  response words.
- outValid  out  Requesters  response valid.
- outReady  in  Requesters  response accept.
- reqData  out  CsrType  request to the shared target.
- reqValid  out  1  request valid.
- reqReady  in  1  target accepts the request.
- respData  in  CsrFbType  response from the target.
- respValid  in  1  response valid.
- respReady  out  1  arbiter accepts the response.
- grantId  out  IdxWidth  index of the current or most recent owner.
- busy  out  1  high in every state except StArb.

## Operation
- Reset is internally synchronized/pipelined per ResetSync/SyncCycles/ResetPipeline.
- Reset values: inReady=0, outValid=0, outData='0, reqValid=0, reqData='0, respReady=0, grantId=0, busy=0, state=StArb, lastGrant=Requesters-1, so requester 0 wins first.
- StArb:
  - The winner is the first asserted inValid, searching from lastGrant+1 and wrapping modulo Requesters.
  - inReady[winner] is combinational (state==StArb and winner exists); all other inReady are 0.
  - On the accept edge: reqData<=inData[winner], grantId<=winner, lastGrant<=winner, reqValid<=1, go to StReq.
- StReq: reqValid held high with reqData stable. When reqReady: reqValid<=0, respReady<=1, go to StWait.
- StWait: when respValid && respReady: outData[grantId]<=respData, outValid[grantId]<=1, respReady<=0, go to StResp.
- StResp: when outReady[grantId]: outValid<=0, go to StArb.
- Responses are never delivered to a non-granted requester. outData of other requesters holds its previous value.
- A respValid arriving outside StWait is ignored (respReady=0).
- Requesters=1: the search degenerates to index 0; behaviour is otherwise identical.
- Reset asserted in any state aborts the transaction: all outputs return to reset values on the next edge and no partial response is delivered.

## Timing
- Accept edge (cycle 0) -> reqValid high in cycle 1. Minimum request latency is 1 cycle.
- reqReady in cycle n -> respReady high in cycle n+1.
- respValid accepted in cycle k -> outValid high in cycle k+1.
- outReady in cycle m -> inReady can assert again in cycle m+1.
- Minimum transaction length is 4 cycles with zero downstream wait.
- Fairness: while all requesters keep inValid high, grants rotate 0,1,...,N-1,0. The worst-case wait is N-1 transactions.
- No combinational path from inValid to reqValid, or from respValid to outValid.

## Structure
- Shared types (csr_32_s, csr_32_fb_s) come from oclib_pkg. No new package content is needed.
- Reset handling uses oclib_module_reset.
- One natural sub-module, oclib_rr_pick: a combinational rotate-priority picker. Inputs are the request vector and lastGrant; outputs are the winner index and an any-request flag. It is reused by other oclib arbiters.
- The state machine lives in this module; the enum is local: StArb, StReq, StWait, StResp.

## Test plan
- Reset, then idle: all outputs at reset values. Raise inValid[1]: inReady[1]=1 the same cycle; reqValid=1 next cycle with reqData equal to the input word; grantId=1.
- Requesters=4, all inValid held, target responds immediately: grantId sequence is 0,1,2,3,0, one grant every 4 cycles.
- Target holds reqReady=0 for 10 cycles: reqValid and reqData stay stable, inReady stays 0, busy=1 throughout.
- Response with outReady[2]=0 for 5 cycles: outValid[2] held with outData[2] stable; no other outValid rises; the next grant comes 1 cycle after outReady.
- Spurious respValid in StArb: no outValid asserts. Reset asserted in StWait: next cycle all outputs at reset values, and the next grant goes to requester 0.
